divisor_frecuencia_prog: RTL and testbench

- Multi-channel, runtime-programmable frequency divider for the interface clock tree.
- Generates one square-wave output and one single-cycle tick (clock-enable) per channel from clk_in.
- Divisors load over a simple write port and take effect glitch-free at the channel's next wrap, or immediately on request.
- A global sync input phase-aligns all channels.

---
 rtl/divisor_frecuencia_prog.sv | 100 ++++++++++
 tb/tb_divisor_frecuencia_prog.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_frecuencia_prog.sv
// Multi-channel programmable frequency divider: per channel a one-cycle tick every D
// cycles and a 50% square wave of period 2*D, with glitch-free divisor updates.
module divisor_frecuencia_prog #(
    parameter int NCH         = 4,
    parameter int W           = 27,
    parameter int DIV_DEFAULT = 50_000_000
) (
    input  logic                                     clk_in,
    input  logic                                     reset,
    input  logic                                     en,
    input  logic                                     sync,
    input  logic                                     wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [W-1:0]                             wr_div,
    input  logic                                     wr_restart,
    output logic [NCH-1:0]                           tick,
    output logic [NCH-1:0]                           div_frec,
    output logic [NCH-1:0]                           upd_pend
);

    localparam logic [W-1:0] DEF = W'(DIV_DEFAULT);

    logic [W-1:0]   d_q   [NCH];
    logic [W-1:0]   p_q   [NCH];
    logic [W-1:0]   cnt_q [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] frec_q;

    logic [NCH-1:0] sel;
    logic [NCH-1:0] wrap;
    logic [W-1:0]   div_eff;

    // A zero divisor is stored as 1 so the counter compare below never underflows.
    assign div_eff = (wr_div == '0) ? W'(1) : wr_div;

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        sel  = '0;
        wrap = '0;
        for (int c = 0; c < NCH; c++) begin
            sel[c]  = wr_en && (int'(wr_ch) == c);
            wrap[c] = (cnt_q[c] == d_q[c] - W'(1));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so D <= P always
    // sees the pending value from before any same-cycle write.
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                d_q[c]    <= DEF;
                p_q[c]    <= DEF;
                cnt_q[c]  <= '0;
                pend_q[c] <= 1'b0;
                tick_q[c] <= 1'b0;
                frec_q[c] <= 1'b0;
            end else if (sync) begin
                cnt_q[c]  <= '0;
                tick_q[c] <= 1'b0;
                frec_q[c] <= 1'b0;
                if (pend_q[c]) d_q[c] <= p_q[c];
                pend_q[c] <= 1'b0;
                // A plain write landing with sync stays pending for the next wrap.
                if (sel[c] && !wr_restart) begin
                    p_q[c]    <= div_eff;
                    pend_q[c] <= 1'b1;
                end
            end else if (sel[c] && wr_restart) begin
                d_q[c]    <= div_eff;
                cnt_q[c]  <= '0;
                tick_q[c] <= 1'b0;
                frec_q[c] <= 1'b0;
                pend_q[c] <= 1'b0;
            end else begin
                if (en && wrap[c]) begin
                    cnt_q[c]  <= '0;
                    tick_q[c] <= 1'b1;
                    frec_q[c] <= ~frec_q[c];
                    if (pend_q[c]) begin
                        d_q[c]    <= p_q[c];
                        pend_q[c] <= 1'b0;
                    end
                end else begin
                    if (en) cnt_q[c] <= cnt_q[c] + W'(1);
                    tick_q[c] <= 1'b0;
                end
                if (sel[c]) begin
                    p_q[c]    <= div_eff;
                    pend_q[c] <= 1'b1;
                end
            end
        end
    end

    assign tick     = tick_q;
    assign div_frec = frec_q;
    assign upd_pend = pend_q;

endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Directed bench for divisor_frecuencia_prog: a period-based model checked every cycle,
// plus literal expectations; a second 3-channel instance sees a write to channel 3.
module tb_divisor_frecuencia_prog;

    logic       clk_in = 1'b0;
    logic       reset, en, sync, wr_en, wr_restart;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [3:0] tick_a, frec_a, pend_a;
    logic [2:0] tick_b, frec_b, pend_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: per channel the active/pending divisor, cycles elapsed in the current
    // period, and how many ticks since the last restart (square wave = parity).
    int m_d [4], m_p [4], m_age [4], m_ticks [4];
    bit m_pend [4], m_tick [4];

    divisor_frecuencia_prog #(.NCH(4), .W(8), .DIV_DEFAULT(4)) dut_a (
        .clk_in(clk_in), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .wr_restart(wr_restart),
        .tick(tick_a), .div_frec(frec_a), .upd_pend(pend_a)
    );

    divisor_frecuencia_prog #(.NCH(3), .W(8), .DIV_DEFAULT(4)) dut_b (
        .clk_in(clk_in), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .wr_restart(wr_restart),
        .tick(tick_b), .div_frec(frec_b), .upd_pend(pend_b)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int eff;
        eff = (wr_div == 0) ? 1 : int'(wr_div);
        for (int c = 0; c < 4; c++) begin
            bit hit;
            hit = wr_en && (int'(wr_ch) == c);
            if (reset) begin
                m_d[c] = 4; m_p[c] = 4; m_age[c] = 0; m_ticks[c] = 0;
                m_pend[c] = 0; m_tick[c] = 0;
            end else if (sync) begin
                m_age[c] = 0; m_ticks[c] = 0; m_tick[c] = 0;
                if (m_pend[c]) m_d[c] = m_p[c];
                m_pend[c] = 0;
                if (hit && !wr_restart) begin m_p[c] = eff; m_pend[c] = 1; end
            end else if (hit && wr_restart) begin
                m_d[c] = eff; m_age[c] = 0; m_ticks[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
            end else begin
                m_tick[c] = 0;
                if (en) begin
                    m_age[c]++;
                    if (m_age[c] == m_d[c]) begin
                        m_tick[c] = 1; m_ticks[c]++; m_age[c] = 0;
                        if (m_pend[c]) begin m_d[c] = m_p[c]; m_pend[c] = 0; end
                    end
                end
                if (hit) begin m_p[c] = eff; m_pend[c] = 1; end
            end
        end
    endtask

    task automatic step(input int n = 1);
        logic [3:0] et, ef, ep;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            model_edge();
            cyc++;
            #1;
            for (int c = 0; c < 4; c++) begin
                et[c] = m_tick[c];
                ef[c] = m_ticks[c][0];
                ep[c] = m_pend[c];
            end
            check("a_tick", {4'b0, tick_a}, {4'b0, et});
            check("a_div_frec", {4'b0, frec_a}, {4'b0, ef});
            check("a_upd_pend", {4'b0, pend_a}, {4'b0, ep});
            check("b_tick", {5'b0, tick_b}, {5'b0, et[2:0]});
            check("b_div_frec", {5'b0, frec_b}, {5'b0, ef[2:0]});
            check("b_upd_pend", {5'b0, pend_b}, {5'b0, ep[2:0]});
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] dv, input logic rs);
        wr_en = 1'b1; wr_ch = ch; wr_div = dv; wr_restart = rs;
    endtask

    task automatic no_write();
        wr_en = 1'b0; wr_ch = 2'd0; wr_div = 8'd0; wr_restart = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; sync = 1'b0;
        no_write();
        step(2);
        check("rst_tick", {4'b0, tick_a}, 8'h00);
        check("rst_frec", {4'b0, frec_a}, 8'h00);
        check("rst_pend", {4'b0, pend_a}, 8'h00);

        // Free run with the default divisor of 4.
        reset = 1'b0; en = 1'b1;
        step(3);
        check("no_early_tick", {4'b0, tick_a}, 8'h00);
        step(1);
        check("tick_edge4", {4'b0, tick_a}, 8'h0f);
        check("frec_edge4", {4'b0, frec_a}, 8'h0f);
        step(4);
        check("tick_edge8", {4'b0, tick_a}, 8'h0f);
        check("frec_edge8", {4'b0, frec_a}, 8'h00);

        // Plain write of 3 to ch1 while its counter is at 1.
        step(1);
        write(2'd1, 8'd3, 1'b0);
        step(1);
        check("pend_after_wr", {4'b0, pend_a}, 8'h02);
        no_write();
        step(1);
        check("pend_held", {4'b0, pend_a}, 8'h02);
        step(1);
        check("tick_edge12", {4'b0, tick_a}, 8'h0f);
        check("pend_applied", {4'b0, pend_a}, 8'h00);
        step(3);
        check("ch1_d3_tick", {4'b0, tick_a}, 8'h02);
        step(1);
        check("others_tick16", {4'b0, tick_a}, 8'h0d);

        // Restart write of 0 to ch2 gives D=1.
        write(2'd2, 8'd0, 1'b1);
        step(1);
        check("restart_tick", {4'b0, tick_a}, 8'h00);
        check("restart_frec", {4'b0, frec_a}, 8'h00);
        no_write();
        step(1);
        check("d1_tick_a", {4'b0, tick_a}, 8'h06);
        check("d1_frec_a", {4'b0, frec_a}, 8'h06);
        step(1);
        check("d1_tick_b", {4'b0, tick_a}, 8'h04);
        check("d1_frec_b", {4'b0, frec_a}, 8'h02);

        // Freeze for 5 cycles mid-count.
        step(3);
        en = 1'b0;
        step(5);
        check("frozen_tick", {4'b0, tick_a}, 8'h00);
        en = 1'b1;
        step(12);

        // Pending D=6 on ch3 applied by sync.
        write(2'd3, 8'd6, 1'b0);
        step(1);
        check("ch3_pending", {4'b0, pend_a}, 8'h08);
        no_write();
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("sync_tick", {4'b0, tick_a}, 8'h00);
        check("sync_frec", {4'b0, frec_a}, 8'h00);
        check("sync_pend", {4'b0, pend_a}, 8'h00);
        step(4);
        check("post_sync4", {4'b0, tick_a}, 8'h05);
        step(2);
        check("post_sync6", {4'b0, tick_a}, 8'h0e);
        step(6);

        // Plain write coincident with sync stays pending; restart write with sync is lost.
        write(2'd0, 8'd5, 1'b0);
        sync = 1'b1;
        step(1);
        check("wr_sync_pend", {4'b0, pend_a}, 8'h01);
        write(2'd1, 8'd7, 1'b1);
        step(1);
        sync = 1'b0;
        no_write();
        step(12);

        // Back-to-back writes to ch0, one of them meeting a wrap.
        for (int i = 0; i < 5; i++) begin
            write(2'd0, 8'(2 + i), 1'b0);
            step(1);
        end
        no_write();
        step(20);

        // Reset mid-operation after writes, then a write to channel 3.
        write(2'd1, 8'd9, 1'b0);
        step(1);
        write(2'd3, 8'd2, 1'b1);
        step(1);
        no_write();
        step(3);
        reset = 1'b1;
        step(1);
        check("rst2_tick", {4'b0, tick_a}, 8'h00);
        check("rst2_frec", {4'b0, frec_a}, 8'h00);
        check("rst2_pend", {4'b0, pend_a}, 8'h00);
        reset = 1'b0;
        write(2'd3, 8'd7, 1'b0);
        step(1);
        no_write();
        check("b_invalid_pend", {5'b0, pend_b}, 8'h00);
        step(3);
        check("rst2_tick4_a", {5'b0, tick_a[2:0]}, 8'h07);
        check("rst2_tick4_b", {5'b0, tick_b}, 8'h07);
        step(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
